// File: rtl/cvxif_pau_q.sv
// cvxif_pau_q: CV-X-IF offload front end for an external posit arithmetic unit.
// In-order slot queue with commit/kill tracking and a start/done engine handshake.
module cvxif_pau_q #(
  parameter int XLEN     = 32,
  parameter int ID_W     = 4,
  parameter int DEPTH    = 4,
  parameter int MIN_WAIT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_instr,
  input  logic [ID_W-1:0] issue_id,
  output logic            issue_accept,
  output logic            issue_writeback,
  output logic [1:0]      issue_register_read,
  input  logic            register_valid,
  output logic            register_ready,
  input  logic [ID_W-1:0] register_id,
  input  logic [XLEN-1:0] register_rs0,
  input  logic [XLEN-1:0] register_rs1,
  input  logic [1:0]      register_rs_valid,
  input  logic            commit_valid,
  input  logic [ID_W-1:0] commit_id,
  input  logic            commit_kill,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [ID_W-1:0] result_id,
  output logic [4:0]      result_rd,
  output logic [XLEN-1:0] result_data,
  output logic            pau_start,
  output logic [2:0]      pau_op,
  output logic [XLEN-1:0] pau_a,
  output logic [XLEN-1:0] pau_b,
  input  logic            pau_done,
  input  logic [XLEN-1:0] pau_result
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int MW = $clog2(MIN_WAIT + 1) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [MW-1:0] WAIT_CNT = MW'(MIN_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_r;
  logic [MW-1:0]   cnt_r;

  logic [DEPTH-1:0] slot_valid_r;
  logic [DEPTH-1:0] slot_ops_r;
  logic [DEPTH-1:0] slot_cmt_r;
  logic [DEPTH-1:0] slot_kill_r;
  logic [ID_W-1:0]  slot_id_r [DEPTH];
  logic [2:0]       slot_op_r [DEPTH];
  logic [4:0]       slot_rd_r [DEPTH];
  logic [XLEN-1:0]  slot_a_r  [DEPTH];
  logic [XLEN-1:0]  slot_b_r  [DEPTH];

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  logic             match_s;
  logic             alloc_s;
  logic             free_s;
  logic             launch_s;
  logic             done_ok_s;
  logic             head_valid_s;
  logic             head_ops_s;
  logic             head_cmt_s;
  logic             head_kill_s;
  logic [DEPTH-1:0] kill_hit_s;
  logic [DEPTH-1:0] cmt_hit_s;
  logic [DEPTH-1:0] ops_hit_s;
  logic             unused_s;

  // funct3 in 000..011 means bit 14 clear
  assign match_s = (issue_instr[6:0] == 7'b1111011) &&
                   (issue_instr[31:25] == 7'b0000000) &&
                   (issue_instr[14] == 1'b0);
  assign unused_s = ^issue_instr[24:15];

  assign issue_ready         = (count_r != FULL_CNT);
  assign alloc_s             = issue_valid & issue_ready & match_s;
  assign issue_accept        = alloc_s;
  assign issue_writeback     = alloc_s;
  assign issue_register_read = {2{alloc_s}};
  assign register_ready      = 1'b1;

  assign head_valid_s = slot_valid_r[rd_ptr_r];
  assign head_ops_s   = slot_ops_r[rd_ptr_r];
  assign head_cmt_s   = slot_cmt_r[rd_ptr_r];
  assign head_kill_s  = slot_kill_r[rd_ptr_r];
  assign done_ok_s    = pau_done & (cnt_r >= WAIT_CNT);
  assign launch_s     = (state_r == ST_IDLE) & head_valid_s & head_ops_s & ~head_kill_s;

  // Per-slot commit, kill and operand match; a kill in the same cycle blocks operand capture
  always_comb begin
    kill_hit_s = '0;
    cmt_hit_s  = '0;
    ops_hit_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit_s[i] = commit_valid & commit_kill & slot_valid_r[i] & ~slot_cmt_r[i] &
                      (slot_id_r[i] == commit_id);
      cmt_hit_s[i]  = commit_valid & ~commit_kill & slot_valid_r[i] & ~slot_kill_r[i] &
                      (slot_id_r[i] == commit_id);
      ops_hit_s[i]  = register_valid & (register_rs_valid == 2'b11) & slot_valid_r[i] &
                      ~slot_ops_r[i] & ~slot_kill_r[i] & ~kill_hit_s[i] &
                      (slot_id_r[i] == register_id);
    end
  end

  // Head retirement: killed heads drop out, finished heads leave on the result handshake
  always_comb begin
    free_s = 1'b0;
    case (state_r)
      ST_IDLE: free_s = head_valid_s & head_kill_s;
      ST_RUN:  free_s = head_valid_s & done_ok_s & head_kill_s;
      ST_HOLD: begin
        if (result_valid) begin
          free_s = result_ready;
        end else begin
          free_s = head_kill_s;
        end
      end
      default: free_s = 1'b0;
    endcase
  end

  // Slot storage and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_r <= '0;
      slot_ops_r   <= '0;
      slot_cmt_r   <= '0;
      slot_kill_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id_r[i] <= '0;
        slot_op_r[i] <= 3'd0;
        slot_rd_r[i] <= 5'd0;
        slot_a_r[i]  <= '0;
        slot_b_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_hit_s[i]) begin
          slot_kill_r[i] <= 1'b1;
        end
        if (cmt_hit_s[i]) begin
          slot_cmt_r[i] <= 1'b1;
        end
        if (ops_hit_s[i]) begin
          slot_ops_r[i] <= 1'b1;
          slot_a_r[i]   <= register_rs0;
          slot_b_r[i]   <= register_rs1;
        end
      end
      if (free_s) begin
        slot_valid_r[rd_ptr_r] <= 1'b0;
      end
      if (alloc_s) begin
        slot_valid_r[wr_ptr_r] <= 1'b1;
        slot_ops_r[wr_ptr_r]   <= 1'b0;
        slot_cmt_r[wr_ptr_r]   <= 1'b0;
        slot_kill_r[wr_ptr_r]  <= 1'b0;
        slot_id_r[wr_ptr_r]    <= issue_id;
        slot_op_r[wr_ptr_r]    <= issue_instr[14:12];
        slot_rd_r[wr_ptr_r]    <= issue_instr[11:7];
      end
    end
  end

  // Ring pointers and occupancy; allocate and free in one cycle leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (alloc_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (free_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({alloc_s, free_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Engine sequencer with registered engine and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      pau_start    <= 1'b0;
      pau_op       <= 3'd0;
      pau_a        <= '0;
      pau_b        <= '0;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_rd    <= 5'd0;
      result_data  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            pau_start <= 1'b1;
            pau_op    <= slot_op_r[rd_ptr_r];
            pau_a     <= slot_a_r[rd_ptr_r];
            pau_b     <= slot_b_r[rd_ptr_r];
          end
        end
        ST_RUN: begin
          if (done_ok_s) begin
            pau_start <= 1'b0;
            if (head_kill_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r      <= ST_HOLD;
              result_data  <= pau_result;
              result_id    <= slot_id_r[rd_ptr_r];
              result_rd    <= slot_rd_r[rd_ptr_r];
              result_valid <= head_cmt_s;
            end
          end else if (cnt_r < WAIT_CNT) begin
            cnt_r <= cnt_r + MW'(1);
          end
        end
        ST_HOLD: begin
          if (result_valid) begin
            if (result_ready) begin
              result_valid <= 1'b0;
              state_r      <= ST_IDLE;
            end
          end else if (head_kill_s) begin
            state_r <= ST_IDLE;
          end else if (head_cmt_s) begin
            result_valid <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvxif_pau_q.sv
// Self-checking bench for cvxif_pau_q: directed scenarios plus randomized batches
// scored against an in-order queue of expected results and a behavioural engine.
module tb_cvxif_pau_q;
  localparam int XLEN = 32;
  localparam int ID_W = 4;
  localparam int DEPTH = 4;
  localparam int MIN_WAIT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [31:0]     issue_instr = 32'h0;
  logic [ID_W-1:0] issue_id = '0;
  logic            issue_accept, issue_writeback;
  logic [1:0]      issue_register_read;
  logic            register_valid = 1'b0;
  logic            register_ready;
  logic [ID_W-1:0] register_id = '0;
  logic [XLEN-1:0] register_rs0 = '0, register_rs1 = '0;
  logic [1:0]      register_rs_valid = 2'b00;
  logic            commit_valid = 1'b0;
  logic [ID_W-1:0] commit_id = '0;
  logic            commit_kill = 1'b0;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic [ID_W-1:0] result_id;
  logic [4:0]      result_rd;
  logic [XLEN-1:0] result_data;
  logic            pau_start;
  logic [2:0]      pau_op;
  logic [XLEN-1:0] pau_a, pau_b;
  logic            pau_done = 1'b0;
  logic [XLEN-1:0] pau_result = '0;

  int n_tests = 0;
  int n_fail = 0;

  int          eng_delay = 0;
  int          eng_k = 0;
  logic        eng_ovr_en = 1'b0;
  logic [31:0] eng_ovr_val = 32'h0;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  cvxif_pau_q #(.XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH), .MIN_WAIT(MIN_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_id(issue_id), .issue_accept(issue_accept), .issue_writeback(issue_writeback),
    .issue_register_read(issue_register_read),
    .register_valid(register_valid), .register_ready(register_ready), .register_id(register_id),
    .register_rs0(register_rs0), .register_rs1(register_rs1), .register_rs_valid(register_rs_valid),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_rd(result_rd), .result_data(result_data),
    .pau_start(pau_start), .pau_op(pau_op), .pau_a(pau_a), .pau_b(pau_b),
    .pau_done(pau_done), .pau_result(pau_result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic of the stand-in engine
  function automatic logic [31:0] eng_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      default: return a ^ b;
    endcase
  endfunction

  // Engine: done from cycle eng_delay of a run; result is garbage before cycle MIN_WAIT
  always @(negedge clk) begin
    if (!pau_start) begin
      eng_k      <= 0;
      pau_done   <= 1'b0;
      pau_result <= 32'h0;
    end else begin
      pau_done   <= (eng_k >= eng_delay);
      pau_result <= (eng_k >= MIN_WAIT) ? (eng_ovr_en ? eng_ovr_val : eng_fn(pau_op, pau_a, pau_b))
                                        : (32'hDEAD0000 | 32'(eng_k));
      eng_k      <= eng_k + 1;
    end
  end

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    logic [9:0] rs;
    rs = 10'($urandom);
    return {f7, rs, f3, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [31:0] instr, input logic [3:0] id, output logic [3:0] resp);
    int g;
    g = 0;
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_id    = id;
    @(negedge clk);
    while (!issue_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    resp = {issue_accept, issue_writeback, issue_register_read};
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic send_ops(input logic [3:0] id, input logic [31:0] a, input logic [31:0] b);
    register_valid    = 1'b1;
    register_id       = id;
    register_rs0      = a;
    register_rs1      = b;
    register_rs_valid = 2'b11;
    tick();
    register_valid    = 1'b0;
    register_rs_valid = 2'b00;
  endtask

  task automatic send_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    tick();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic drain_results(input int n);
    int got;
    int guard;
    exp_t e;
    got = 0;
    guard = 0;
    while (got < n && guard < 400) begin
      result_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (result_valid && result_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if ({result_id, result_rd, result_data} !== {e.id, e.rd, e.data}) begin
          n_fail++;
          $display("FAIL result: got id=%0d rd=%0d data=%h, expected id=%0d rd=%0d data=%h",
                   result_id, result_rd, result_data, e.id, e.rd, e.data);
        end
        got++;
      end
      tick();
      guard++;
    end
    result_ready = 1'b0;
    n_tests++;
    if (got != n) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d results, expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({issue_accept, result_valid, pau_start, result_data, result_id, result_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got acc=%b rv=%b st=%b data=%h id=%h rd=%h, expected all 0",
               issue_accept, result_valid, pau_start, result_data, result_id, result_rd);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (issue_ready !== 1'b1 || register_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got issue_ready=%b register_ready=%b, expected 1 1",
               issue_ready, register_ready);
    end
  endtask

  task automatic test_add();
    logic [3:0] r;
    int lat;
    eng_delay = 0;
    eng_ovr_en = 1'b1;
    eng_ovr_val = 32'h48000000;
    issue_one(mk_instr(7'd0, 3'd0, 5'd7, 7'h7B), 4'd3, r);
    n_tests++;
    if (r !== 4'b1111) begin
      n_fail++;
      $display("FAIL add_accept: got %b expected 1111", r);
    end
    send_commit(4'd3, 1'b0);
    send_ops(4'd3, 32'h40000000, 32'h40000000);
    lat = 0;
    while (!result_valid && lat < 30) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != MIN_WAIT + 2) begin
      n_fail++;
      $display("FAIL add_latency: got %0d cycles expected %0d", lat, MIN_WAIT + 2);
    end
    @(negedge clk);
    n_tests++;
    if (result_valid !== 1'b1 || result_id !== 4'd3 || result_rd !== 5'd7 || result_data !== 32'h48000000) begin
      n_fail++;
      $display("FAIL add_result: got v=%b id=%0d rd=%0d data=%h expected 1 3 7 48000000",
               result_valid, result_id, result_rd, result_data);
    end
    tick();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    n_tests++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_handshake: got result_valid=%b expected 0", result_valid);
    end
    eng_ovr_en = 1'b0;
  endtask

  task automatic test_full();
    logic [3:0] r;
    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [2:0] op [5];
    exp_t e;
    eng_delay = 0;
    for (int i = 0; i < 5; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
      op[i] = 3'($urandom_range(0, 3));
    end
    for (int i = 0; i < 4; i++) begin
      issue_one(mk_instr(7'd0, op[i], 5'(i + 1), 7'h7B), 4'(i), r);
      n_tests++;
      if (r !== 4'b1111) begin
        n_fail++;
        $display("FAIL full_accept%0d: got %b expected 1111", i, r);
      end
      exp_q.push_back('{id: 4'(i), rd: 5'(i + 1), data: eng_fn(op[i], a[i], b[i])});
    end
    @(negedge clk);
    n_tests++;
    if (issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b expected 0", issue_ready);
    end
    tick();
    for (int i = 0; i < 4; i++) send_commit(4'(i), 1'b0);
    for (int i = 0; i < 4; i++) send_ops(4'(i), a[i], b[i]);
    issue_valid = 1'b1;
    issue_instr = mk_instr(7'd0, op[4], 5'd20, 7'h7B);
    issue_id    = 4'd4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b0 || issue_accept !== 1'b0) begin
        n_fail++;
        $display("FAIL full_hold: got ready=%b accept=%b expected 0 0", issue_ready, issue_accept);
      end
      tick();
    end
    result_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (result_valid !== 1'b1 || result_id !== e.id || result_data !== e.data) begin
      n_fail++;
      $display("FAIL full_first: got v=%b id=%0d data=%h expected 1 %0d %h",
               result_valid, result_id, result_data, e.id, e.data);
    end
    tick();
    result_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (issue_ready !== 1'b1 || issue_accept !== 1'b1) begin
      n_fail++;
      $display("FAIL full_fifth: got ready=%b accept=%b expected 1 1", issue_ready, issue_accept);
    end
    tick();
    issue_valid = 1'b0;
    send_commit(4'd4, 1'b0);
    send_ops(4'd4, a[4], b[4]);
    exp_q.push_back('{id: 4'd4, rd: 5'd20, data: eng_fn(op[4], a[4], b[4])});
    drain_results(4);
  endtask

  task automatic test_nomatch();
    logic [3:0] r;
    logic [31:0] bad [3];
    bad[0] = mk_instr(7'b0000001, 3'd0, 5'd3, 7'h7B);
    bad[1] = mk_instr(7'd0, 3'd4, 5'd3, 7'h7B);
    bad[2] = mk_instr(7'd0, 3'd1, 5'd3, 7'h33);
    for (int i = 0; i < 3; i++) begin
      issue_one(bad[i], 4'd8, r);
      n_tests++;
      if (r !== 4'b0000) begin
        n_fail++;
        $display("FAIL nomatch_resp%0d: got %b expected 0000", i, r);
      end
    end
    send_ops(4'd8, 32'h1, 32'h2);
    repeat (5) tick();
    n_tests++;
    if (issue_ready !== 1'b1 || pau_start !== 1'b0) begin
      n_fail++;
      $display("FAIL nomatch_noslot: got ready=%b start=%b expected 1 0", issue_ready, pau_start);
    end
  endtask

  task automatic test_kill_run();
    logic [3:0] r;
    logic [31:0] a5, b5, a6, b6;
    int g;
    a5 = $urandom; b5 = $urandom; a6 = $urandom; b6 = $urandom;
    eng_delay = 6;
    issue_one(mk_instr(7'd0, 3'd2, 5'd9, 7'h7B), 4'd5, r);
    issue_one(mk_instr(7'd0, 3'd1, 5'd10, 7'h7B), 4'd6, r);
    send_commit(4'd6, 1'b0);
    send_ops(4'd5, a5, b5);
    send_ops(4'd6, a6, b6);
    g = 0;
    while (!pau_start && g < 20) begin tick(); g++; end
    n_tests++;
    if (pau_start !== 1'b1 || pau_a !== a5 || pau_b !== b5 || pau_op !== 3'd2) begin
      n_fail++;
      $display("FAIL killrun_launch: got st=%b op=%0d a=%h b=%h expected 1 2 %h %h",
               pau_start, pau_op, pau_a, pau_b, a5, b5);
    end
    send_commit(4'd5, 1'b1);
    result_ready = 1'b1;
    g = 0;
    while (pau_start && g < 40) begin
      n_tests++;
      if (result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL killrun_noresult: got result_valid=%b expected 0", result_valid);
      end
      tick();
      g++;
    end
    g = 0;
    while (!pau_start && g < 40) begin
      n_tests++;
      if (result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL killrun_gap: got result_valid=%b expected 0", result_valid);
      end
      tick();
      g++;
    end
    result_ready = 1'b0;
    n_tests++;
    if (pau_start !== 1'b1 || pau_a !== a6 || pau_b !== b6 || pau_op !== 3'd1) begin
      n_fail++;
      $display("FAIL killrun_next: got st=%b op=%0d a=%h b=%h expected 1 1 %h %h",
               pau_start, pau_op, pau_a, pau_b, a6, b6);
    end
    exp_q.push_back('{id: 4'd6, rd: 5'd10, data: eng_fn(3'd1, a6, b6)});
    drain_results(1);
  endtask

  task automatic test_kill_queued();
    logic [3:0] r;
    int starts;
    eng_delay = 0;
    issue_one(mk_instr(7'd0, 3'd3, 5'd1, 7'h7B), 4'd9, r);
    commit_valid = 1'b1; commit_id = 4'd9; commit_kill = 1'b1;
    register_valid = 1'b1; register_id = 4'd9; register_rs_valid = 2'b11;
    register_rs0 = 32'h11; register_rs1 = 32'h22;
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
    register_valid = 1'b0; register_rs_valid = 2'b00;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      issue_one(mk_instr(7'd0, 3'd0, 5'd2, 7'h7B), 4'(10 + i), r);
      if (pau_start) starts++;
      n_tests++;
      if (r !== 4'b1111) begin
        n_fail++;
        $display("FAIL killq_slotfree%0d: got %b expected 1111", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_commit(4'(10 + i), 1'b1);
      if (pau_start) starts++;
    end
    repeat (4) begin
      tick();
      if (pau_start) starts++;
    end
    n_tests++;
    if (starts != 0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL killq_nostart: got starts=%0d ready=%b expected 0 1", starts, issue_ready);
    end
  endtask

  task automatic test_hold_uncommitted();
    logic [3:0] r;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    eng_delay = 0;
    issue_one(mk_instr(7'd0, 3'd0, 5'd12, 7'h7B), 4'd2, r);
    send_ops(4'd2, a, b);
    result_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_tests++;
      if (result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_wait: got result_valid=%b expected 0", result_valid);
      end
      tick();
    end
    result_ready = 1'b0;
    send_commit(4'd2, 1'b0);
    exp_q.push_back('{id: 4'd2, rd: 5'd12, data: eng_fn(3'd0, a, b)});
    drain_results(1);
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] r;
    int g;
    int seen;
    eng_delay = 20;
    issue_one(mk_instr(7'd0, 3'd0, 5'd4, 7'h7B), 4'd1, r);
    issue_one(mk_instr(7'd0, 3'd2, 5'd5, 7'h7B), 4'd2, r);
    send_commit(4'd1, 1'b0);
    send_commit(4'd2, 1'b0);
    send_ops(4'd1, 32'h5, 32'h6);
    send_ops(4'd2, 32'h7, 32'h8);
    g = 0;
    while (!pau_start && g < 20) begin tick(); g++; end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({issue_accept, result_valid, pau_start, result_data, result_id, result_rd} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got acc=%b rv=%b st=%b data=%h id=%h rd=%h expected all 0",
               issue_accept, result_valid, pau_start, result_data, result_id, result_rd);
    end
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    eng_delay = 0;
    tick();
    n_tests++;
    if (issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %b expected 1", issue_ready);
    end
    result_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (result_valid || pau_start) seen++;
    end
    result_ready = 1'b0;
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [2:0]  f3 [4];
    logic [6:0]  f7 [4];
    logic [4:0]  rd [4];
    logic        acc [4];
    logic        kill [4];
    int order [4];
    int n, ncommit, j, t;
    logic exp_acc;
    for (int batch = 0; batch < 8; batch++) begin
      n = $urandom_range(1, 4);
      ncommit = 0;
      eng_delay = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        a[i] = $urandom; b[i] = $urandom;
        f3[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        f7[i] = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
        rd[i] = 5'($urandom);
        kill[i] = ($urandom_range(0, 2) == 0);
        exp_acc = (f7[i] == 7'd0) && (f3[i] < 3'd4);
        issue_one(mk_instr(f7[i], f3[i], rd[i], 7'h7B), 4'(batch * 4 + i), r);
        acc[i] = r[3];
        n_tests++;
        if (r !== {exp_acc, exp_acc, exp_acc, exp_acc}) begin
          n_fail++;
          $display("FAIL rand_accept b%0d i%0d: got %b expected %b", batch, i, r, {4{exp_acc}});
        end
        if (exp_acc && !kill[i]) begin
          exp_q.push_back('{id: 4'(batch * 4 + i), rd: rd[i], data: eng_fn(f3[i], a[i], b[i])});
          ncommit++;
        end
        order[i] = i;
      end
      for (int i = 0; i < n; i++) send_commit(4'(batch * 4 + i), kill[i]);
      for (int i = n - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < n; i++) send_ops(4'(batch * 4 + order[i]), a[order[i]], b[order[i]]);
      drain_results(ncommit);
      repeat (3) tick();
      n_tests++;
      if (issue_ready !== 1'b1 || pau_start !== 1'b0 || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL rand_idle b%0d: got ready=%b start=%b pending=%0d expected 1 0 0",
                 batch, issue_ready, pau_start, exp_q.size());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_full();
    test_nomatch();
    test_kill_run();
    test_kill_queued();
    test_hold_uncommitted();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cvxif_pau_q.md
CVXIF_PAU_Q -- requirements
Module: cvxif_pau_q

Interface
REQ-001 Parameter XLEN, 32, register and posit operand width; PAU_N = XLEN.
REQ-002 Parameter ID_W, 4, instruction-ID width.
REQ-003 Parameter DEPTH, 4, in-flight instruction slots; power of two, >=2.
REQ-004 Parameter MIN_WAIT, 2, minimum cycles after launch before pau_done is sampled.
REQ-005 Ports, one per line:
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset; asynchronous, active-low
  issue_valid  in  1  offload request
  issue_ready  out  1  block can take a request
  issue_instr  in  32  instruction word
  issue_id  in  ID_W  instruction ID
  issue_accept  out  1  instruction is a PAU op
  issue_writeback  out  1  rd is written
  issue_register_read  out  2  rs0/rs1 needed
  register_valid  in  1  operand transfer
  register_ready  out  1  constant 1
  register_id  in  ID_W  operand owner ID
  register_rs0  in  XLEN  operand a
  register_rs1  in  XLEN  operand b
  register_rs_valid  in  2  per-operand valid
  commit_valid  in  1  commit/kill event
  commit_id  in  ID_W  target ID
  commit_kill  in  1  1 = kill, 0 = commit
  result_valid  out  1  result available
  result_ready  in  1  core takes result
  result_id  out  ID_W  result owner ID
  result_rd  out  5  destination register
  result_data  out  XLEN  result
  pau_start  out  1  engine run request, held until done is taken
  pau_op  out  3  funct3 to engine
  pau_a  out  XLEN  engine operand a
  pau_b  out  XLEN  engine operand b
  pau_done  in  1  engine result valid
  pau_result  in  XLEN  engine result

Function
REQ-006 Match: opcode[6:0]=1111011, funct7=0, funct3 in {000 ADD, 001 SUB, 010 MUL, 011 DIV}.
REQ-007 issue_ready SHALL be 1 when fewer than DEPTH slots are in use; full blocks issue with no same-cycle retire bypass.
REQ-008 When issue_valid and issue_ready: matching -> issue_accept=1, writeback=1, register_read=11, slot allocated (id, op, rd=instr[11:7]); else all three 0, no slot.
REQ-009 Operands: register_valid, rs_valid=11 and register_id equal to a slot awaiting operands -> rs0/rs1 captured; other cases ignored.
REQ-010 Slots SHALL execute strictly in allocation order; only the oldest slot is launched.
REQ-011 Engine FSM: IDLE -> RUN when head has operands and is not killed; pau_start=1, pau_op/a/b from head throughout RUN; counter cleared at launch.
REQ-012 In RUN, pau_done is ignored until counter >= MIN_WAIT; first done after that -> pau_result registered, FSM -> HOLD.
REQ-013 HOLD: if head committed, result_valid=1 with head id/rd/data until result_ready; handshake frees head, FSM -> IDLE next cycle.
REQ-014 An uncommitted head in HOLD SHALL wait; result_valid stays 0 until its commit arrives.
REQ-015 Commit (kill=0) to a live ID marks it committed; kill to a live, uncommitted ID marks it killed; other commit events are ignored.
REQ-016 Killed head not yet launched: freed in one cycle, no pau_start. Killed head in RUN: engine finishes, result dropped, slot freed, no result_valid.
REQ-017 Same cycle, same ID, kill and operand arrival: kill wins.
REQ-018 Occupancy counter SHALL handle simultaneous allocate and free (net unchanged); read/write pointers wrap modulo DEPTH.
REQ-019 Minimum latency, operands-to-result_valid for a committed head: MIN_WAIT+2 cycles.

Reset
REQ-020 rst_n low SHALL asynchronously clear all slots, pointers, counters and FSM (IDLE).
REQ-021 During reset, issue_accept, result_valid, pau_start, result_data, result_id and result_rd SHALL be 0, and issue_ready SHALL be 1 once released.
REQ-022 Reset mid-RUN abandons the engine operation; no result is produced after release.

Verification
REQ-023 ADD id 3, rs0=0x40000000, rs1=0x40000000, commit; engine returns 0x48000000 -> result_valid, id=3, data=0x48000000.
REQ-024 Fill 4 slots; issue_ready=0; 5th held until first result handshake, then accepted.
REQ-025 funct7=0000001 -> issue_accept=0, no slot, issue_ready remains 1.
REQ-026 Kill id 5 while in RUN; engine done -> no result_valid, next slot launches.
REQ-027 pau_done at counter 0..MIN_WAIT-1 ignored; done at counter MIN_WAIT accepted.
REQ-028 rst_n low mid-RUN with 2 slots held -> all outputs 0 at once; after release, issue_ready=1.
